color_period_meter: RTL and testbench

Front-end measurement stage for the colour sensor. It drives the sensor's filter-select lines through the four filter settings in turn and measures the sensor output period under each one in `clk` cycles. It then presents the four counts as one frame with a single-cycle valid strobe. The colour classifier downstream consumes each frame instead of counting raw cycles itself.

---
 rtl/color_pkg.sv | 50 +++++
 rtl/sensor_edge_sync.sv | 34 +++
 rtl/color_period_meter.sv | 198 +++++++++++++++++++
 tb/tb_color_period_meter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// ============================================================================
// color_pkg: filter codes, channel and FSM encodings for the colour front end.
// Revision: 1.0
// ============================================================================
`default_nettype none

package color_pkg;

  localparam logic [7:0] FILT_RED   = 8'h11;
  localparam logic [7:0] FILT_BLUE  = 8'h51;
  localparam logic [7:0] FILT_CLEAR = 8'h15;
  localparam logic [7:0] FILT_GREEN = 8'h55;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_G = 2'd3
  } chan_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ARM     = 3'd2,
    ST_MEASURE = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic logic [7:0] filt_code(input chan_t ch);
    case (ch)
      CH_R:    return FILT_RED;
      CH_B:    return FILT_BLUE;
      CH_C:    return FILT_CLEAR;
      default: return FILT_GREEN;
    endcase
  endfunction

  function automatic chan_t next_chan(input chan_t ch);
    case (ch)
      CH_R:    return CH_B;
      CH_B:    return CH_C;
      CH_C:    return CH_G;
      default: return CH_R;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_edge_sync.sv
// ============================================================================
// sensor_edge_sync: 2-FF synchroniser followed by a one-cycle rising-edge pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sensor_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/color_period_meter.sv
// ============================================================================
// color_period_meter: steps the sensor filter through R/B/C/G, measures the
// sensor period under each and publishes the four counts as one frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module color_period_meter
  import color_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int N_PERIODS    = 1,
  parameter int SETTLE_EDGES = 2,
  parameter int TIMEOUT      = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor,
  input  logic             run,
  output logic [7:0]       JA,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_g,
  output logic             frame_valid,
  output logic [3:0]       timeout,
  output logic             busy
);

  localparam int              WD_W        = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMEOUT - 1);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_EDGES - 1);
  localparam logic [7:0]      EDGE_LAST   = 8'(N_PERIODS - 1);

  logic edge_w;

  sensor_edge_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sensor_i (sensor),
    .edge_o   (edge_w)
  );

  state_t           state_q, state_d;
  chan_t            chan_q, chan_d;
  logic [7:0]       settle_q, settle_d;
  logic [7:0]       ecnt_q, ecnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] shadow_q [4];
  logic [CNT_W-1:0] shadow_d [4];
  logic [CNT_W-1:0] out_q [4];
  logic [CNT_W-1:0] out_d [4];
  logic [3:0]       tof_q, tof_d;
  logic [3:0]       tout_q, tout_d;
  logic             fv_q, fv_d;

  logic             wd_expired_w;
  logic             abort_w;
  logic [CNT_W-1:0] cyc_inc_w;

  assign wd_expired_w = (wd_q == WD_LAST);
  assign cyc_inc_w    = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    settle_d = settle_q;
    ecnt_d   = ecnt_q;
    cyc_d    = cyc_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    tof_d    = tof_q;
    tout_d   = tout_q;
    fv_d     = 1'b0;
    abort_w  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        chan_d   = CH_R;
        settle_d = '0;
        ecnt_d   = '0;
        cyc_d    = '0;
        tof_d    = '0;
        if (run) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (SETTLE_EDGES == 0) begin
          state_d = ST_ARM;
        end else if (edge_w) begin
          if (settle_q == SETTLE_LAST) state_d = ST_ARM;
          else                         settle_d = settle_q + 8'd1;
        end else begin
          abort_w = wd_expired_w;
        end
      end
      ST_ARM: begin
        if (edge_w) begin
          cyc_d   = '0;
          state_d = ST_MEASURE;
        end else begin
          abort_w = wd_expired_w;
        end
      end
      ST_MEASURE: begin
        // Stored value includes the cycle of the final edge, so it equals
        // the edge-to-edge distance rather than one less.
        cyc_d = cyc_inc_w;
        if (edge_w) begin
          if (ecnt_q == EDGE_LAST) begin
            shadow_d[chan_q] = cyc_inc_w;
            state_d          = ST_NEXT;
          end else begin
            ecnt_d = ecnt_q + 8'd1;
          end
        end else begin
          abort_w = wd_expired_w;
        end
      end
      ST_NEXT: begin
        settle_d = '0;
        ecnt_d   = '0;
        if (chan_q == CH_G) begin
          state_d = ST_DONE;
        end else begin
          chan_d  = next_chan(chan_q);
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        out_d    = shadow_q;
        tout_d   = tof_q;
        fv_d     = 1'b1;
        chan_d   = CH_R;
        settle_d = '0;
        ecnt_d   = '0;
        tof_d    = '0;
        state_d  = run ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_w) begin
      shadow_d[chan_q] = '1;
      tof_d[chan_q]    = 1'b1;
      state_d          = ST_NEXT;
    end

    // Watchdog restarts on any accepted edge and whenever the state changes.
    if ((state_d != state_q) || edge_w) begin
      wd_d = '0;
    end else if ((state_q == ST_SETTLE) || (state_q == ST_ARM) || (state_q == ST_MEASURE)) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      chan_q   <= CH_R;
      settle_q <= '0;
      ecnt_q   <= '0;
      cyc_q    <= '0;
      wd_q     <= '0;
      shadow_q <= '{default: '0};
      out_q    <= '{default: '0};
      tof_q    <= '0;
      tout_q   <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      settle_q <= settle_d;
      ecnt_q   <= ecnt_d;
      cyc_q    <= cyc_d;
      wd_q     <= wd_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      tof_q    <= tof_d;
      tout_q   <= tout_d;
      fv_q     <= fv_d;
    end
  end

  assign JA          = filt_code(chan_q);
  assign cnt_r       = out_q[0];
  assign cnt_b       = out_q[1];
  assign cnt_c       = out_q[2];
  assign cnt_g       = out_q[3];
  assign timeout     = tout_q;
  assign frame_valid = fv_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_color_period_meter.sv
// ============================================================================
// tb_color_period_meter: two meter instances (32-bit/N=4 and 8-bit/N=1) fed by
// a filter-aware sensor model; frames compared against table/model values.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_color_period_meter;

  localparam int NP_A = 4;
  localparam int NP_B = 1;
  localparam int W_A  = 32;
  localparam int W_B  = 8;

  typedef struct packed {
    logic [3:0][15:0] per;
    logic [3:0]       dead;
    logic [3:0][31:0] exp;
    logic [3:0]       exp_to;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a = 1'b0, rst_n_b = 1'b0;
  logic run_a = 1'b0, run_b = 1'b0;
  logic sens_a, sens_b;
  logic [7:0] ja_a, ja_b;
  logic [31:0] ca_r, ca_b, ca_c, ca_g;
  logic [7:0]  cb_r, cb_b, cb_c, cb_g;
  logic fv_a, fv_b, busy_a, busy_b;
  logic [3:0] to_a, to_b;

  color_period_meter #(.CNT_W(W_A), .N_PERIODS(NP_A), .SETTLE_EDGES(1), .TIMEOUT(5000)) u_a (
    .clk(clk), .rst_n(rst_n_a), .sensor(sens_a), .run(run_a), .JA(ja_a),
    .cnt_r(ca_r), .cnt_b(ca_b), .cnt_c(ca_c), .cnt_g(ca_g),
    .frame_valid(fv_a), .timeout(to_a), .busy(busy_a));

  color_period_meter #(.CNT_W(W_B), .N_PERIODS(NP_B), .SETTLE_EDGES(1), .TIMEOUT(5000)) u_b (
    .clk(clk), .rst_n(rst_n_b), .sensor(sens_b), .run(run_b), .JA(ja_b),
    .cnt_r(cb_r), .cnt_b(cb_b), .cnt_c(cb_c), .cnt_g(cb_g),
    .frame_valid(fv_b), .timeout(to_b), .busy(busy_b));

  // Sensor model: square wave whose period depends on the selected filter.
  int per_a [4] = '{default: 100};
  int per_b [4] = '{default: 100};
  bit dead_a [4] = '{default: 1'b0};
  bit dead_b [4] = '{default: 1'b0};
  int ph_a = 0, ph_b = 0;

  function automatic int chan_of(input logic [7:0] ja);
    case (ja)
      8'h51:   return 1;
      8'h15:   return 2;
      8'h55:   return 3;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) ph_a <= (ph_a + 1 >= per_a[chan_of(ja_a)]) ? 0 : ph_a + 1;
  always @(negedge clk) ph_b <= (ph_b + 1 >= per_b[chan_of(ja_b)]) ? 0 : ph_b + 1;
  always_comb sens_a = !dead_a[chan_of(ja_a)] && (ph_a < per_a[chan_of(ja_a)] / 2);
  always_comb sens_b = !dead_b[chan_of(ja_b)] && (ph_b < per_b[chan_of(ja_b)] / 2);

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected count: N periods, clipped at the counter's all-ones value.
  function automatic logic [31:0] model(input int per, input bit dead, input int np, input int w);
    longint full, m;
    full = (longint'(1) << w) - 1;
    m    = longint'(np) * longint'(per);
    if (dead) return 32'(full);
    return 32'((m > full) ? full : m);
  endfunction

  function automatic vec_t mk(input int r, input int b, input int c, input int g,
                              input logic [3:0] dead,
                              input logic [31:0] er, input logic [31:0] eb,
                              input logic [31:0] ec, input logic [31:0] eg,
                              input logic [3:0] to);
    vec_t v;
    v.per[0] = 16'(r); v.per[1] = 16'(b); v.per[2] = 16'(c); v.per[3] = 16'(g);
    v.dead   = dead;
    v.exp[0] = er; v.exp[1] = eb; v.exp[2] = ec; v.exp[3] = eg;
    v.exp_to = to;
    return v;
  endfunction

  function automatic vec_t mk_rand(input int np, input int w, input int lo, input int hi);
    vec_t v;
    v = '0;
    for (int c = 0; c < 4; c++) begin
      v.per[c] = 16'($urandom_range(hi, lo));
      v.exp[c] = model(int'(v.per[c]), 1'b0, np, w);
    end
    return v;
  endfunction

  function automatic logic [31:0] cnt_of(input int inst, input int ch);
    if (inst == 0) begin
      case (ch)
        0: return ca_r; 1: return ca_b; 2: return ca_c; default: return ca_g;
      endcase
    end
    case (ch)
      0: return {24'd0, cb_r}; 1: return {24'd0, cb_b}; 2: return {24'd0, cb_c};
      default: return {24'd0, cb_g};
    endcase
  endfunction

  task automatic apply(input int inst, input vec_t v);
    for (int c = 0; c < 4; c++) begin
      if (inst == 0) begin per_a[c] = int'(v.per[c]); dead_a[c] = v.dead[c]; end
      else           begin per_b[c] = int'(v.per[c]); dead_b[c] = v.dead[c]; end
    end
  endtask

  task automatic check_frame(input int inst, input vec_t v, input string tag);
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_cnt%0d", tag, c), cnt_of(inst, c), v.exp[c]);
    check({tag, "_timeout"}, {28'd0, (inst == 0) ? to_a : to_b}, {28'd0, v.exp_to});
  endtask

  task automatic check_reset(input int inst, input string tag);
    for (int c = 0; c < 4; c++) check($sformatf("%s_cnt%0d", tag, c), cnt_of(inst, c), 32'd0);
    check({tag, "_ja"},      {24'd0, (inst == 0) ? ja_a : ja_b}, 32'h11);
    check({tag, "_timeout"}, {28'd0, (inst == 0) ? to_a : to_b}, 32'd0);
    check({tag, "_busy"},    {31'd0, (inst == 0) ? busy_a : busy_b}, 32'd0);
    check({tag, "_fv"},      {31'd0, (inst == 0) ? fv_a : fv_b}, 32'd0);
  endtask

  task automatic wait_fv(input int inst, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (((inst == 0) ? fv_a : fv_b) == 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tot++;
      $display("FAIL frame_wait inst%0d: no frame_valid in %0d cycles, expected a strobe", inst, budget);
    end
  endtask

  task automatic wait_ja(input int inst, input logic [7:0] code, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (((inst == 0) ? ja_a : ja_b) == code) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tot++;
      $display("FAIL ja_wait inst%0d: JA never showed %0h in %0d cycles", inst, code, budget);
    end
  endtask

  vec_t tab_a [6];
  vec_t tab_b [4];

  task automatic seq_a();
    bit ok;
    int strobes;
    repeat (3) @(posedge clk);
    #1;
    check_reset(0, "a_por");
    rst_n_a = 1'b1;
    apply(0, tab_a[0]);
    run_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_fv(0, 20000, ok);
      if (ok) check_frame(0, tab_a[i], $sformatf("a_frame%0d", i));
      apply(0, tab_a[(i + 1) % 6 == 0 ? 0 : i + 1]);
      @(posedge clk); #1;
      check($sformatf("a_fv_pulse%0d", i), {31'd0, fv_a}, 32'd0);
    end

    // Reset in the middle of the green measurement.
    apply(0, tab_a[0]);
    wait_ja(0, 8'h55, 20000, ok);
    repeat (1300) @(posedge clk);
    #1;
    check("a_busy_green", {31'd0, busy_a}, 32'd1);
    rst_n_a = 1'b0;
    @(posedge clk); #1;
    check_reset(0, "a_midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    wait_fv(0, 20000, ok);
    if (ok) check_frame(0, tab_a[0], "a_after_reset");

    // Drop run while the clear channel is being measured.
    wait_ja(0, 8'h15, 20000, ok);
    run_a = 1'b0;
    wait_fv(0, 20000, ok);
    if (ok) check_frame(0, tab_a[0], "a_rundrop");
    @(posedge clk); #1;
    check("a_rundrop_busy", {31'd0, busy_a}, 32'd0);
    check("a_rundrop_ja", {24'd0, ja_a}, 32'h11);
    strobes = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (fv_a) strobes++;
    end
    check("a_idle_strobes", 32'(strobes), 32'd0);
    check("a_idle_busy", {31'd0, busy_a}, 32'd0);
  endtask

  task automatic seq_b();
    bit ok;
    logic [7:0] seen [$];
    repeat (3) @(posedge clk);
    #1;
    check_reset(1, "b_por");
    rst_n_b = 1'b1;
    apply(1, tab_b[0]);
    run_b = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (fv_b) begin ok = 1'b1; break; end
      if (seen.size() == 0 || seen[$] != ja_b) seen.push_back(ja_b);
    end
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL b_first_frame: no frame_valid in 20000 cycles, expected a strobe");
    check("b_ja_changes", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      check("b_ja_seq0", {24'd0, seen[0]}, 32'h11);
      check("b_ja_seq1", {24'd0, seen[1]}, 32'h51);
      check("b_ja_seq2", {24'd0, seen[2]}, 32'h15);
      check("b_ja_seq3", {24'd0, seen[3]}, 32'h55);
    end
    if (ok) check_frame(1, tab_b[0], "b_frame0");
    for (int i = 1; i < 4; i++) begin
      apply(1, tab_b[i]);
      @(posedge clk); #1;
      check($sformatf("b_fv_pulse%0d", i), {31'd0, fv_b}, 32'd0);
      wait_fv(1, 20000, ok);
      if (ok) check_frame(1, tab_b[i], $sformatf("b_frame%0d", i));
    end
    run_b = 1'b0;
  endtask

  initial begin
    tab_a[0] = mk(100, 300, 150, 400, 4'b0000, 400, 1200, 600, 1600, 4'b0000);
    tab_a[1] = mk(200, 200, 200, 200, 4'b0000, 800, 800, 800, 800, 4'b0000);
    tab_a[2] = mk(200, 200, 200, 200, 4'b0010, 800, 32'hFFFF_FFFF, 800, 800, 4'b0010);
    tab_a[3] = mk(50, 120, 80, 30, 4'b0000, 200, 480, 320, 120, 4'b0000);
    tab_a[4] = mk_rand(NP_A, W_A, 30, 300);
    tab_a[5] = mk_rand(NP_A, W_A, 30, 300);
    tab_b[0] = mk(200, 200, 200, 200, 4'b0000, 200, 200, 200, 200, 4'b0000);
    tab_b[1] = mk(300, 300, 300, 300, 4'b0000, 255, 255, 255, 255, 4'b0000);
    tab_b[2] = mk(100, 300, 50, 250, 4'b0000, 100, 255, 50, 250, 4'b0000);
    tab_b[3] = mk_rand(NP_B, W_B, 30, 400);

    fork
      seq_a();
      seq_b();
    join

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
